// File: rtl/div_pkg.sv
// Shared types and widths for the divider request scheduler.
package div_pkg;

    localparam int unsigned DIVIDEND_W = 10;
    localparam int unsigned DIVISOR_W  = 3;
    localparam int unsigned QUOT_W     = 20;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_DIV0 = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        DRAIN
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the pointer and wraps.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  pointer,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  index
);

    // Walk offsets from farthest to nearest so the nearest requester overrides.
    always_comb begin
        grant = '0;
        index = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (req[i] && (((int'(pointer) + k) % int'(N_REQ)) == i)) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    index    = ID_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/div_req_scheduler.sv
// Shares one iterative divider among N_REQ requesters, one operation at a time,
// with divide-by-zero screening and a watchdog that resets a hung core.
module div_req_scheduler
    import div_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DIVIDEND_W-1:0] req_dividend,
    input  logic [N_REQ*DIVISOR_W-1:0]  req_divisor,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [QUOT_W-1:0]           rsp_data,
    output logic [1:0]                  rsp_err,
    output logic                        div_in_valid,
    output logic [DIVIDEND_W-1:0]       div_in_data_1,
    output logic [DIVISOR_W-1:0]        div_in_data_2,
    input  logic                        div_out_valid,
    input  logic [QUOT_W-1:0]           div_out_data,
    output logic                        div_rst_n
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DIVIDEND_W-1:0] dividend_q, dividend_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [QUOT_W-1:0]     data_q, data_d;
    logic [1:0]            err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  div_rst_q;

    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  accept;
    logic                  timeout_hit;
    logic [DIVIDEND_W-1:0] sel_dividend;
    logic [DIVISOR_W-1:0]  sel_divisor;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req_valid),
        .pointer (ptr_q),
        .grant   (grant),
        .index   (grant_idx)
    );

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                sel_dividend = req_dividend[i*DIVIDEND_W +: DIVIDEND_W];
                sel_divisor  = req_divisor[i*DIVISOR_W +: DIVISOR_W];
            end
        end
    end

    assign timeout_hit = (state_q == WAIT) && !div_out_valid
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Watchdog pulse is combinational so the core is reset at the abort edge itself.
    assign div_rst_n     = div_rst_q & ~timeout_hit;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_id        = id_q;
    assign rsp_data      = data_q;
    assign rsp_err       = err_q;
    assign div_in_valid  = (state_q == ISSUE) && !div_out_valid;
    assign div_in_data_1 = dividend_q;
    assign div_in_data_2 = divisor_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        data_d     = data_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d      = grant_idx;
                    id_d       = grant_idx;
                    dividend_d = sel_dividend;
                    divisor_d  = sel_divisor;
                    if (sel_divisor == '0) begin
                        data_d  = '1;
                        err_d   = ERR_DIV0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // A stale out_valid holds us here; the issue happens once it clears.
                if (!div_out_valid) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (div_out_valid) begin
                    data_d  = div_out_data;
                    err_d   = ERR_OK;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    data_d  = '0;
                    err_d   = ERR_TMO;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!div_out_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            data_q     <= '0;
            err_q      <= ERR_OK;
            cnt_q      <= '0;
            div_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            data_q     <= data_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            div_rst_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_req_scheduler.sv
// Directed bench for div_req_scheduler with a behavioural divider core and a response scoreboard.
module tb_div_req_scheduler;
    import div_pkg::*;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 64;
    localparam int CORE_C  = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*10-1:0]    req_dividend;
    logic [N_REQ*3-1:0]     req_divisor;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [19:0]            rsp_data;
    logic [1:0]             rsp_err;
    logic                   div_in_valid;
    logic [9:0]             div_in_data_1;
    logic [2:0]             div_in_data_2;
    logic                   div_out_valid;
    logic [19:0]            div_out_data;
    logic                   div_rst_n;

    always #5 clk = ~clk;

    div_req_scheduler #(
        .N_REQ   (N_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .div_in_valid  (div_in_valid),
        .div_in_data_1 (div_in_data_1),
        .div_in_data_2 (div_in_data_2),
        .div_out_valid (div_out_valid),
        .div_out_data  (div_out_data),
        .div_rst_n     (div_rst_n)
    );

    function automatic logic [19:0] quot(input logic [9:0] a, input logic [2:0] b);
        logic [19:0] n;
        n = {a, 10'd0};
        return n / {17'd0, b};
    endfunction

    // Core model: one load edge plus CORE_C compute edges, then out_valid held 3 cycles.
    logic core_busy;
    int   core_cnt;
    int   core_hold;
    bit   core_hang = 1'b0;

    always @(posedge clk) begin
        if (div_rst_n !== 1'b1) begin
            core_busy     <= 1'b0;
            core_cnt      <= 0;
            core_hold     <= 0;
            div_out_valid <= 1'b0;
            div_out_data  <= '0;
        end else if (div_in_valid && !core_hang) begin
            core_busy    <= 1'b1;
            core_cnt     <= CORE_C;
            div_out_data <= quot(div_in_data_1, div_in_data_2);
        end else if (core_busy && core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                div_out_valid <= 1'b1;
                core_hold     <= 3;
                core_busy     <= 1'b0;
            end
        end else if (div_out_valid) begin
            core_hold <= core_hold - 1;
            if (core_hold == 1) div_out_valid <= 1'b0;
        end
    end

    typedef struct {
        int          id;
        logic [19:0] data;
        logic [1:0]  err;
        int          lat;
        int          acc_cyc;
        logic [9:0]  dvd;
        logic [2:0]  dvs;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   issue_cnt = 0;
    int   drl_cnt = 0;
    int   drl_cyc = 0;
    int   last_acc = 0;
    logic rv_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample one cycle just after the driving negedge, then advance to the next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (rst_n) begin
            if (div_in_valid) begin
                issue_cnt++;
                if (sb.size() > 0) begin
                    check("in_dividend", 32'(div_in_data_1), 32'(sb[0].dvd));
                    check("in_divisor", 32'(div_in_data_2), 32'(sb[0].dvs));
                end
            end
            if (div_rst_n === 1'b0) begin
                drl_cnt++;
                drl_cyc = cyc;
            end
            if (rsp_valid && !rv_prev && sb.size() > 0)
                check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id      = i;
                    e.dvd     = req_dividend[i*10 +: 10];
                    e.dvs     = req_divisor[i*3 +: 3];
                    e.acc_cyc = cyc;
                    if (e.dvs == 3'd0) begin
                        e.data = 20'hFFFFF; e.err = ERR_DIV0; e.lat = 1;
                    end else if (core_hang) begin
                        e.data = 20'd0; e.err = ERR_TMO; e.lat = TIMEOUT + 2;
                    end else begin
                        e.data = quot(e.dvd, e.dvs); e.err = ERR_OK; e.lat = CORE_C + 3;
                    end
                    sb.push_back(e);
                    grants.push_back(i);
                    n_acc++;
                    last_acc = cyc;
                end
            end
        end
        rv_prev = rsp_valid;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_accept(input int i);
        int n = 0;
        int a0 = n_acc;
        while (n_acc == a0 && n < 300) begin
            tick();
            n++;
        end
        check("accept_wait", 32'(n < 300), 32'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic request(input int i, input logic [9:0] dvd, input logic [2:0] dvs);
        req_dividend[i*10 +: 10] = dvd;
        req_divisor[i*3 +: 3]    = dvs;
        req_valid[i]             = 1'b1;
        wait_accept(i);
    endtask

    task automatic run_until_idle(input string tag);
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_drain"}, 32'(n < 300), 32'd1);
        repeat (4) tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_in_valid"}, 32'(div_in_valid), 32'd0);
        check({tag, "_in_data_1"}, 32'(div_in_data_1), 32'd0);
        check({tag, "_in_data_2"}, 32'(div_in_data_2), 32'd0);
        check({tag, "_div_rst_n"}, 32'(div_rst_n), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int g0;
        int i0;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        check("div_rst_n_release", 32'(div_rst_n), 32'd1);

        // All requesters held: grant order from reset is 0,1,2,3,0.
        g0 = grants.size();
        for (int i = 0; i < N_REQ; i++) begin
            req_dividend[i*10 +: 10] = 10'(100 + 37 * i);
            req_divisor[i*3 +: 3]    = 3'(i + 1);
        end
        req_valid = '1;
        begin
            int n = 0;
            while (n_acc < g0 + 5 && n < 500) begin
                tick();
                n++;
            end
            check("rr_wait", 32'(n < 500), 32'd1);
        end
        req_valid = '0;
        run_until_idle("rr");
        for (int k = 0; k < 5; k++) check("rr_order", 32'(grants[g0 + k]), 32'(k % N_REQ));

        // Single request from id 2.
        i0 = issue_cnt;
        request(2, 10'd12, 3'd4);
        run_until_idle("single");
        check("single_issue_cnt", 32'(issue_cnt - i0), 32'd1);

        // Divide-by-zero never touches the core.
        i0 = issue_cnt;
        request(1, 10'd5, 3'd0);
        run_until_idle("div0");
        check("div0_issue_cnt", 32'(issue_cnt - i0), 32'd0);

        // Hung core: watchdog pulse at WAIT cycle TIMEOUT-1, then recovery.
        core_hang = 1'b1;
        drl_cnt   = 0;
        request(3, 10'd200, 3'd3);
        run_until_idle("tmo");
        check("tmo_rst_pulses", 32'(drl_cnt), 32'd1);
        check("tmo_rst_cycle", 32'(drl_cyc - last_acc), 32'(TIMEOUT + 1));
        core_hang = 1'b0;
        request(0, 10'd999, 3'd7);
        run_until_idle("post_tmo");

        // Backpressure: response held, no new accept or issue.
        rsp_ready = 1'b0;
        request(2, 10'd300, 3'd5);
        begin
            int n = 0;
            while (!rsp_valid && n < 100) begin
                tick();
                n++;
            end
            check("bp_rsp_wait", 32'(n < 100), 32'd1);
        end
        req_dividend[1*10 +: 10] = 10'd77;
        req_divisor[1*3 +: 3]    = 3'd2;
        req_valid[1]             = 1'b1;
        i0 = issue_cnt;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", 32'(rsp_data), 32'(quot(10'd300, 3'd5)));
            check("bp_id", 32'(rsp_id), 32'd2);
            check("bp_err", 32'(rsp_err), 32'(ERR_OK));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        check("bp_no_issue", 32'(issue_cnt - i0), 32'd0);
        rsp_ready = 1'b1;
        wait_accept(1);
        run_until_idle("bp");
        check("bp_next_grant", 32'(grants[grants.size() - 1]), 32'd1);

        // Reset while waiting on the core.
        request(2, 10'd64, 3'd2);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        sb.delete();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            req_dividend[i*10 +: 10] = 10'(500 + i);
            req_divisor[i*3 +: 3]    = 3'(7 - i);
        end
        req_valid = '1;
        wait_accept(0);
        req_valid = '0;
        check("midreset_first_grant", 32'(grants[grants.size() - 1]), 32'd0);
        run_until_idle("midreset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
